// File: rtl/icache_ctrl_if.sv
// Bus bundle for icache_ctrl: fetch request, array/checker, ifill (L2) and,
// with ICACHE_CTRL_PERF_CNT_EN defined, the hit/miss performance counters.
// slave = the controller, master = its environment.
interface icache_ctrl_if #(
    parameter int N_WAY         = 4,
    parameter int SET_IDX_WIDTH = 6,
    parameter int TAG_WIDTH     = 20
);
    logic                           req_valid_i;
    logic                           req_ready_o;
    logic [SET_IDX_WIDTH-1:0]       req_idx_i;
    logic [TAG_WIDTH-1:0]           req_tag_i;
    logic                           kill_i;
    logic                           flush_i;
    logic [N_WAY-1:0]               cline_hit_i;
    logic [N_WAY-1:0]               way_valid_i;
    logic                           array_rd_en_o;
    logic [SET_IDX_WIDTH-1:0]       array_idx_o;
    logic                           cmp_enable_o;
    logic [TAG_WIDTH-1:0]           cline_tag_o;
    logic                           resp_valid_o;
    logic                           ifill_req_valid_o;
    logic                           ifill_req_ready_i;
    logic [TAG_WIDTH+SET_IDX_WIDTH-1:0] ifill_req_addr_o;
    logic                           ifill_resp_valid_i;
    logic [N_WAY-1:0]               array_wr_en_o;
    logic                           valid_clr_o;
    logic                           busy_o;
`ifdef ICACHE_CTRL_PERF_CNT_EN
    logic [31:0]                    hit_cnt_o;
    logic [31:0]                    miss_cnt_o;
`endif

    modport slave (
`ifdef ICACHE_CTRL_PERF_CNT_EN
        output hit_cnt_o, output miss_cnt_o,
`endif
        input  req_valid_i, req_idx_i, req_tag_i, kill_i, flush_i,
        input  cline_hit_i, way_valid_i, ifill_req_ready_i, ifill_resp_valid_i,
        output req_ready_o, array_rd_en_o, array_idx_o, cmp_enable_o, cline_tag_o,
        output resp_valid_o, ifill_req_valid_o, ifill_req_addr_o, array_wr_en_o,
        output valid_clr_o, busy_o
    );

    modport master (
`ifdef ICACHE_CTRL_PERF_CNT_EN
        input  hit_cnt_o, input miss_cnt_o,
`endif
        output req_valid_i, req_idx_i, req_tag_i, kill_i, flush_i,
        output cline_hit_i, way_valid_i, ifill_req_ready_i, ifill_resp_valid_i,
        input  req_ready_o, array_rd_en_o, array_idx_o, cmp_enable_o, cline_tag_o,
        input  resp_valid_o, ifill_req_valid_o, ifill_req_addr_o, array_wr_en_o,
        input  valid_clr_o, busy_o
    );
endinterface

// File: rtl/icache_ctrl.sv
// icache_ctrl: instruction-cache lookup sequencer. Accepts fetch requests,
// strobes the tag/data arrays, qualifies the hit checker, handles misses
// (victim pick, ifill handshake, refill write, replay) and walks the whole
// cache on flush.
// Optional feature macro: ICACHE_CTRL_PERF_CNT_EN (hit/miss counters).
module icache_ctrl #(
    parameter int N_WAY         = 4,
    parameter int SET_IDX_WIDTH = 6,
    parameter int TAG_WIDTH     = 20
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    icache_ctrl_if.slave bus
);
    localparam int WAY_W = (N_WAY > 1) ? $clog2(N_WAY) : 1;

    typedef enum logic [2:0] {
        IDLE, LOOKUP, MISS_REQ, WAIT_FILL, REPLAY, FLUSH
    } state_t;

    state_t                   r_state;
    logic [TAG_WIDTH-1:0]     r_tag;
    logic [SET_IDX_WIDTH-1:0] r_idx;
    logic [SET_IDX_WIDTH-1:0] r_flush_cnt;
    logic [WAY_W-1:0]         r_rr_ptr;
    logic [WAY_W-1:0]         r_victim;
    logic                     r_victim_rr;   // victim came from the round-robin pointer
    logic                     r_killed;      // redirect seen while the fill is outstanding
    logic                     r_flush_pend;
    logic                     r_replay;      // current LOOKUP is a post-fill replay

    logic                     w_req_ready;
    logic                     w_accept;
    logic                     w_any_hit;
    logic                     w_lookup_hit;
    logic                     w_miss;
    logic                     w_fill;
    logic                     w_free_found;
    logic [WAY_W-1:0]         w_free_way;
    logic [N_WAY-1:0]         w_victim_oh;

    assign w_req_ready  = (r_state == IDLE) && !bus.flush_i && !r_flush_pend;
    assign w_accept     = w_req_ready && bus.req_valid_i;
    assign w_any_hit    = |bus.cline_hit_i;
    assign w_lookup_hit = (r_state == LOOKUP) && w_any_hit && !bus.kill_i;
    assign w_miss       = (r_state == LOOKUP) && !w_any_hit && !bus.kill_i;
    assign w_fill       = (r_state == WAIT_FILL) && bus.ifill_resp_valid_i;

    // Lowest-index invalid way of the addressed set (descending scan keeps the lowest).
    always_comb begin
        w_free_found = 1'b0;
        w_free_way   = '0;
        for (int i = N_WAY - 1; i >= 0; i--) begin
            if (!bus.way_valid_i[i]) begin
                w_free_found = 1'b1;
                w_free_way   = WAY_W'(i);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_WAY; gi++) begin : g_victim_oh
            assign w_victim_oh[gi] = (r_victim == WAY_W'(gi));
        end
    endgenerate

    assign bus.req_ready_o       = w_req_ready;
    assign bus.array_rd_en_o     = w_accept || (r_state == REPLAY);
    assign bus.array_idx_o       = (r_state == IDLE)  ? bus.req_idx_i :
                                   (r_state == FLUSH) ? r_flush_cnt   : r_idx;
    assign bus.cmp_enable_o      = (r_state == LOOKUP);
    assign bus.cline_tag_o       = r_tag;
    assign bus.resp_valid_o      = w_lookup_hit;
    assign bus.ifill_req_valid_o = (r_state == MISS_REQ);
    assign bus.ifill_req_addr_o  = {r_tag, r_idx};
    assign bus.array_wr_en_o     = w_fill ? w_victim_oh : '0;
    assign bus.valid_clr_o       = (r_state == FLUSH);
    assign bus.busy_o            = (r_state != IDLE);

    // Main sequencer: state, request latches, victim, round-robin, flush walk.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state      <= IDLE;
            r_tag        <= '0;
            r_idx        <= '0;
            r_flush_cnt  <= '0;
            r_rr_ptr     <= '0;
            r_victim     <= '0;
            r_victim_rr  <= 1'b0;
            r_killed     <= 1'b0;
            r_flush_pend <= 1'b0;
            r_replay     <= 1'b0;
        end else begin
            // A flush arriving mid-miss waits until the controller is idle again.
            if (bus.flush_i && (r_state != IDLE) && (r_state != FLUSH))
                r_flush_pend <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (bus.flush_i || r_flush_pend) begin
                        r_flush_cnt <= '0;
                        r_state     <= FLUSH;
                    end else if (bus.req_valid_i) begin
                        r_tag    <= bus.req_tag_i;
                        r_idx    <= bus.req_idx_i;
                        r_replay <= 1'b0;
                        r_state  <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    r_replay <= 1'b0;
                    if (bus.kill_i || w_any_hit) begin
                        r_state <= IDLE;
                    end else begin
                        r_victim    <= w_free_found ? w_free_way : r_rr_ptr;
                        r_victim_rr <= !w_free_found;
                        r_state     <= MISS_REQ;
                    end
                end
                MISS_REQ: begin
                    // Once the handshake completes the request is committed.
                    if (bus.ifill_req_ready_i) begin
                        r_killed <= bus.kill_i;
                        r_state  <= WAIT_FILL;
                    end else if (bus.kill_i) begin
                        r_state <= IDLE;
                    end
                end
                WAIT_FILL: begin
                    if (bus.ifill_resp_valid_i) begin
                        if (r_victim_rr)
                            r_rr_ptr <= r_rr_ptr + WAY_W'(1);
                        r_killed <= 1'b0;
                        r_state  <= (r_killed || bus.kill_i) ? IDLE : REPLAY;
                    end else if (bus.kill_i) begin
                        r_killed <= 1'b1;
                    end
                end
                REPLAY: begin
                    r_replay <= 1'b1;
                    r_state  <= LOOKUP;
                end
                FLUSH: begin
                    r_flush_cnt <= r_flush_cnt + SET_IDX_WIDTH'(1);
                    if (r_flush_cnt == '1) begin
                        r_flush_pend <= 1'b0;
                        r_rr_ptr     <= '0;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef ICACHE_CTRL_PERF_CNT_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    // Free-running wrap-around counters of first-time hits and miss entries.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_lookup_hit && !r_replay)
                r_hit_cnt <= r_hit_cnt + 32'd1;
            if (w_miss)
                r_miss_cnt <= r_miss_cnt + 32'd1;
        end
    end

    assign bus.hit_cnt_o  = r_hit_cnt;
    assign bus.miss_cnt_o = r_miss_cnt;
`endif
endmodule

// File: tb/tb_icache_ctrl.sv
// Self-checking bench for icache_ctrl: a vector table of lookups/misses plus
// hand-written kill, flush and reset sequences; responses, fill requests and
// refill writes are checked against a queue-based scoreboard.
module tb_icache_ctrl;
    localparam int NW = 4;
    localparam int SW = 6;
    localparam int TW = 20;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    icache_ctrl_if #(.N_WAY(NW), .SET_IDX_WIDTH(SW), .TAG_WIDTH(TW)) bus ();

    icache_ctrl #(.N_WAY(NW), .SET_IDX_WIDTH(SW), .TAG_WIDTH(TW)) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed { logic [SW-1:0] idx; logic [TW-1:0] tag; } resp_t;
    typedef struct packed { logic [SW-1:0] idx; logic [NW-1:0] we;  } wr_t;
    typedef struct {
        logic [SW-1:0] idx;
        logic [TW-1:0] tag;
        logic [NW-1:0] wv;
        logic [NW-1:0] hit;
        logic [NW-1:0] vic;
        bit            exp_hit;
    } vec_t;

    resp_t            resp_q[$];
    logic [TW+SW-1:0] fill_q[$];
    wr_t              wr_q[$];
    vec_t             vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every response, ifill handshake and refill write must be expected.
    always @(negedge clk) begin : monitor
        resp_t            e_r;
        wr_t              e_w;
        logic [TW+SW-1:0] e_f;
        if (rstn) begin
            if (bus.resp_valid_o) begin
                if (resp_q.size() == 0) chk("resp_unexpected", 64'd1, 64'd0);
                else begin
                    e_r = resp_q.pop_front();
                    chk("resp_tag", 64'(bus.cline_tag_o), 64'(e_r.tag));
                    chk("resp_idx", 64'(bus.array_idx_o), 64'(e_r.idx));
                end
            end
            if (bus.ifill_req_valid_o && bus.ifill_req_ready_i) begin
                if (fill_q.size() == 0) chk("ifill_unexpected", 64'd1, 64'd0);
                else begin
                    e_f = fill_q.pop_front();
                    chk("ifill_addr_sb", 64'(bus.ifill_req_addr_o), 64'(e_f));
                end
            end
            if (bus.array_wr_en_o != '0) begin
                chk("wr_exclusive", 64'(bus.array_rd_en_o | bus.valid_clr_o), 64'd0);
                if (wr_q.size() == 0) chk("wr_unexpected", 64'd1, 64'd0);
                else begin
                    e_w = wr_q.pop_front();
                    chk("wr_idx", 64'(bus.array_idx_o), 64'(e_w.idx));
                    chk("wr_way", 64'(bus.array_wr_en_o), 64'(e_w.we));
                end
            end
        end
    end

    // One fetch request, starting at posedge+1 with the DUT idle; ends at posedge+1 idle.
    task automatic do_txn(input logic [SW-1:0] idx, input logic [TW-1:0] tag,
                          input logic [NW-1:0] wv, input logic [NW-1:0] hit,
                          input logic [NW-1:0] vic, input bit exp_hit,
                          input bit kill_wait, input bit flush_req);
        bus.req_valid_i = 1'b1;
        bus.req_idx_i   = idx;
        bus.req_tag_i   = tag;
        @(negedge clk);
        chk("req_ready", 64'(bus.req_ready_o), 64'd1);
        chk("acc_rd_en", 64'(bus.array_rd_en_o), 64'd1);
        chk("acc_idx", 64'(bus.array_idx_o), 64'(idx));
        if (exp_hit) resp_q.push_back('{idx: idx, tag: tag});
        else begin
            fill_q.push_back({tag, idx});
            wr_q.push_back('{idx: idx, we: vic});
            if (!kill_wait) resp_q.push_back('{idx: idx, tag: tag});
        end
        tick();
        bus.req_valid_i = 1'b0;
        bus.way_valid_i = wv;
        bus.cline_hit_i = hit;
        @(negedge clk);
        chk("cmp_enable", 64'(bus.cmp_enable_o), 64'd1);
        chk("resp_timing", 64'(bus.resp_valid_o), 64'(exp_hit));
        tick();
        bus.cline_hit_i = '0;
        if (exp_hit) begin
            @(negedge clk);
            chk("hit_no_ifill", 64'(bus.ifill_req_valid_o), 64'd0);
            chk("hit_idle", 64'(bus.busy_o), 64'd0);
            tick();
        end else begin
            bus.flush_i = flush_req;
            @(negedge clk);
            chk("ifill_valid", 64'(bus.ifill_req_valid_o), 64'd1);
            chk("ifill_addr", 64'(bus.ifill_req_addr_o), 64'({tag, idx}));
            tick();
            bus.flush_i = 1'b0;
            @(negedge clk);
            chk("ifill_hold", 64'(bus.ifill_req_valid_o), 64'd1);
            tick();
            bus.ifill_req_ready_i = 1'b1;
            @(negedge clk);
            tick();
            bus.ifill_req_ready_i = 1'b0;
            @(negedge clk);
            chk("wait_no_valid", 64'(bus.ifill_req_valid_o), 64'd0);
            chk("wait_busy", 64'(bus.busy_o), 64'd1);
            tick();
            bus.kill_i = kill_wait;
            tick();
            bus.kill_i = 1'b0;
            bus.ifill_resp_valid_i = 1'b1;
            @(negedge clk);
            chk("fill_we", 64'(bus.array_wr_en_o), 64'(vic));
            tick();
            bus.ifill_resp_valid_i = 1'b0;
            if (kill_wait) begin
                @(negedge clk);
                chk("kill_idle", 64'(bus.busy_o), 64'd0);
                chk("kill_ready", 64'(bus.req_ready_o), 64'd1);
                chk("kill_no_replay", 64'(bus.array_rd_en_o | bus.resp_valid_o), 64'd0);
                tick();
            end else begin
                @(negedge clk);
                chk("replay_rd_en", 64'(bus.array_rd_en_o), 64'd1);
                chk("replay_idx", 64'(bus.array_idx_o), 64'(idx));
                tick();
                bus.cline_hit_i = vic;
                @(negedge clk);
                chk("replay_resp", 64'(bus.resp_valid_o), 64'd1);
                tick();
                bus.cline_hit_i = '0;
            end
        end
        $display("TXN idx=%0d tag=%05h hit=%0b victim=%04b kill=%0b flush=%0b",
                 idx, tag, exp_hit, vic, kill_wait, flush_req);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid_i = 1'b0; bus.req_idx_i = '0; bus.req_tag_i = '0;
        bus.kill_i = 1'b0; bus.flush_i = 1'b0;
        bus.cline_hit_i = '0; bus.way_valid_i = '0;
        bus.ifill_req_ready_i = 1'b0; bus.ifill_resp_valid_i = 1'b0;

        vecs[0] = '{idx: 6'd5,  tag: 20'hABCDE, wv: 4'b0000, hit: 4'b0000, vic: 4'b0001, exp_hit: 1'b0};
        vecs[1] = '{idx: 6'd5,  tag: 20'hABCDE, wv: 4'b0101, hit: 4'b0100, vic: 4'b0000, exp_hit: 1'b1};
        vecs[2] = '{idx: 6'd3,  tag: 20'h11111, wv: 4'b1111, hit: 4'b0000, vic: 4'b0001, exp_hit: 1'b0};
        vecs[3] = '{idx: 6'd3,  tag: 20'h22222, wv: 4'b1111, hit: 4'b0000, vic: 4'b0010, exp_hit: 1'b0};
        vecs[4] = '{idx: 6'd3,  tag: 20'h33333, wv: 4'b1111, hit: 4'b0000, vic: 4'b0100, exp_hit: 1'b0};
        vecs[5] = '{idx: 6'd3,  tag: 20'h44444, wv: 4'b1111, hit: 4'b0000, vic: 4'b1000, exp_hit: 1'b0};
        vecs[6] = '{idx: 6'd3,  tag: 20'h55555, wv: 4'b1111, hit: 4'b0000, vic: 4'b0001, exp_hit: 1'b0};
        vecs[7] = '{idx: 6'd9,  tag: 20'h0F0F0, wv: 4'b1011, hit: 4'b0000, vic: 4'b0100, exp_hit: 1'b0};
        vecs[8] = '{idx: 6'd9,  tag: 20'h0F0F1, wv: 4'b1111, hit: 4'b0000, vic: 4'b0010, exp_hit: 1'b0};
        vecs[9] = '{idx: 6'd63, tag: 20'hFFFFF, wv: 4'b1111, hit: 4'b1000, vic: 4'b0000, exp_hit: 1'b1};

        // Reset state
        @(negedge clk);
        chk("rst_busy", 64'(bus.busy_o), 64'd0);
        chk("rst_ifill", 64'(bus.ifill_req_valid_o), 64'd0);
        chk("rst_outs", 64'({bus.cmp_enable_o, bus.resp_valid_o, bus.valid_clr_o, bus.array_wr_en_o}), 64'd0);
        chk("rst_tag", 64'(bus.cline_tag_o), 64'd0);
        @(posedge clk); #1 rstn = 1'b1;
        @(negedge clk);
        chk("rst_ready", 64'(bus.req_ready_o), 64'd1);
        tick();

        for (int i = 0; i < 10; i++)
            do_txn(vecs[i].idx, vecs[i].tag, vecs[i].wv, vecs[i].hit, vecs[i].vic,
                   vecs[i].exp_hit, 1'b0, 1'b0);

        // Kill during LOOKUP: no response, no miss.
        bus.req_valid_i = 1'b1; bus.req_idx_i = 6'd8; bus.req_tag_i = 20'h77777;
        tick();
        bus.req_valid_i = 1'b0; bus.cline_hit_i = 4'b0001; bus.way_valid_i = 4'b1111; bus.kill_i = 1'b1;
        @(negedge clk);
        chk("klook_resp", 64'(bus.resp_valid_o), 64'd0);
        tick();
        bus.kill_i = 1'b0; bus.cline_hit_i = '0;
        @(negedge clk);
        chk("klook_idle", 64'(bus.busy_o | bus.ifill_req_valid_o), 64'd0);
        tick();
        $display("TXN idx=8 tag=77777 killed in lookup");

        // Kill during WAIT_FILL: fill still written (rr=2 -> way 2), then idle.
        do_txn(6'd7, 20'h12345, 4'b1111, 4'b0000, 4'b0100, 1'b0, 1'b1, 1'b0);

        // Flush during MISS_REQ: miss completes first (invalid way 3, rr stays 3).
        do_txn(6'd2, 20'h0AAAA, 4'b0111, 4'b0000, 4'b1000, 1'b0, 1'b0, 1'b1);
        bus.req_valid_i = 1'b1; bus.req_idx_i = 6'd5; bus.req_tag_i = 20'h00005;
        @(negedge clk);
        chk("pend_stall", 64'(bus.req_ready_o), 64'd0);
        chk("pend_no_clr", 64'(bus.valid_clr_o), 64'd0);
        tick();
        for (int i = 0; i < 64; i++) begin
            bus.flush_i = (i == 10);
            @(negedge clk);
            chk("flush_clr", 64'(bus.valid_clr_o), 64'd1);
            chk("flush_idx", 64'(bus.array_idx_o), 64'(i));
            chk("flush_stall", 64'(bus.req_ready_o), 64'd0);
            tick();
        end
        bus.flush_i = 1'b0; bus.req_valid_i = 1'b0;
        @(negedge clk);
        chk("flush_done_clr", 64'(bus.valid_clr_o), 64'd0);
        chk("flush_done_ready", 64'(bus.req_ready_o), 64'd1);
        tick();
        $display("TXN flush walk 64 sets");

        // Round-robin pointer restarts at way 0 after flush.
        do_txn(6'd4, 20'h44404, 4'b1111, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0);

`ifdef ICACHE_CTRL_PERF_CNT_EN
        @(negedge clk);
        chk("hit_cnt", 64'(bus.hit_cnt_o), 64'd2);
        chk("miss_cnt", 64'(bus.miss_cnt_o), 64'd11);
        tick();
`endif

        // Reset in MISS_REQ; a late ifill response must be ignored.
        bus.req_valid_i = 1'b1; bus.req_idx_i = 6'd1; bus.req_tag_i = 20'h00001;
        tick();
        bus.req_valid_i = 1'b0; bus.way_valid_i = 4'b0000;
        tick();
        @(negedge clk);
        chk("pre_rst_ifill", 64'(bus.ifill_req_valid_o), 64'd1);
        #1 rstn = 1'b0;
        #1;
        chk("async_rst_ifill", 64'(bus.ifill_req_valid_o), 64'd0);
        chk("async_rst_busy", 64'(bus.busy_o), 64'd0);
        tick();
        rstn = 1'b1;
        bus.ifill_resp_valid_i = 1'b1;
        @(negedge clk);
        chk("post_rst_no_wr", 64'(bus.array_wr_en_o), 64'd0);
        chk("post_rst_idle", 64'(bus.busy_o), 64'd0);
        tick();
        bus.ifill_resp_valid_i = 1'b0;
        $display("TXN reset during miss");

        chk("sb_drain", 64'(resp_q.size() + fill_q.size() + wr_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
